// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1 iterations (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Operand magnitude capture, radix-2 shift-add core and sign fix-up.
module seq_mult_datapath
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 last,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] a_abs_q;
    logic             neg_q;

    logic             sgn_c;
    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;
    logic [WIDTH-1:0] addend_c;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    shifted_c;
    logic [PW-1:0]    fixed_c;

    // Magnitudes at accept, partial-product add, shifted result and sign fix-up.
    always_comb begin
        sgn_c     = SIGNED_EN & signed_mode;
        a_abs_c   = (sgn_c && multiplicand[WIDTH-1]) ? (WIDTH'(0) - multiplicand) : multiplicand;
        b_abs_c   = (sgn_c && multiplier[WIDTH-1])   ? (WIDTH'(0) - multiplier)   : multiplier;
        addend_c  = q_q[0] ? a_abs_q : WIDTH'(0);
        sum_c     = {1'b0, acc_q} + {1'b0, addend_c};
        shifted_c = {sum_c, q_q[WIDTH-1:1]};
        fixed_c   = neg_q ? (PW'(0) - shifted_c) : shifted_c;
    end

    // Operand/accumulator registers; product captured on the final iteration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            q_q     <= '0;
            a_abs_q <= '0;
            neg_q   <= 1'b0;
            product <= '0;
        end else if (load) begin
            acc_q   <= '0;
            q_q     <= b_abs_c;
            a_abs_q <= a_abs_c;
            neg_q   <= sgn_c & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
        end else if (step) begin
            acc_q <= sum_c[WIDTH:1];
            q_q   <= {sum_c[0], q_q[WIDTH-1:1]};
            if (last) begin
                product <= fixed_c;
            end
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Sequential WIDTH x WIDTH multiplier with valid/ready on both sides.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] count_q;
    logic          accept_c;
    logic          step_c;
    logic          last_c;
    logic          in_ready_d;
    logic          busy_d;
    logic          out_valid_d;

    assign accept_c = in_valid && in_ready;
    assign step_c   = (state_q == CALC);
    assign last_c   = step_c && (count_q == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = CALC;
            CALC:    if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the flags register with it.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
        end
    end

    // Iteration counter, cleared on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept_c) begin
            count_q <= '0;
        end else if (step_c) begin
            count_q <= count_q + CW'(1);
        end
    end

    seq_mult_datapath #(
        .WIDTH     (WIDTH),
        .SIGNED_EN (SIGNED_EN)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load         (accept_c),
        .step         (step_c),
        .last         (last_c),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .product      (product)
    );

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench: signed-capable DUT plus an unsigned-only twin on the same inputs.
module tb_seq_mult_param;

    localparam int unsigned W  = 16;
    localparam int unsigned NV = 13;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic          busy;

    logic          u_in_ready;
    logic          u_out_valid;
    logic [2*W-1:0] u_product;
    logic          u_busy;

    int checks = 0;
    int passes = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp_uq[$];

    // Directed vectors: A, B, signed_mode, expected (signed DUT), expected (unsigned twin)
    localparam logic [15:0] VA [NV] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h0006, 16'h0000, 16'hFFFF,
                                        16'h8000, 16'h7FFF, 16'h8000, 16'h1234, 16'h0005, 16'hFFFF, 16'h0002};
    localparam logic [15:0] VB [NV] = '{16'hFFFF, 16'h0007, 16'h8000, 16'h0007, 16'hFFFF, 16'hFFFF,
                                        16'h0001, 16'h8000, 16'h8000, 16'h0010, 16'hFFFE, 16'h0002, 16'hFFFF};
    localparam logic        VM [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [31:0] VE [NV] = '{32'hFFFE0001, 32'hFFFFFFEB, 32'h40000000, 32'h0000002A, 32'h00000000,
                                        32'h00000001, 32'hFFFF8000, 32'hC0008000, 32'h40000000, 32'h00012340,
                                        32'hFFFFFFF6, 32'hFFFFFFFE, 32'hFFFFFFFE};
    localparam logic [31:0] VU [NV] = '{32'hFFFE0001, 32'h0006FFEB, 32'h40000000, 32'h0000002A, 32'h00000000,
                                        32'hFFFE0001, 32'h00008000, 32'h3FFF8000, 32'h40000000, 32'h00012340,
                                        32'h0004FFF6, 32'h0001FFFE, 32'h0001FFFE};

    seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (u_in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .out_valid    (u_out_valid),
        .out_ready    (out_ready),
        .product      (u_product),
        .busy         (u_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Present one operation and return just after the edge that accepts it.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [31:0] e, input logic [31:0] eu, input bit push);
        int n;
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        signed_mode  = m;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout_in_ready", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            if (push) begin
                exp_q.push_back(e);
                exp_uq.push_back(eu);
            end
            @(posedge clk); #1;
        end
    endtask

    // Wait until every expected result has been consumed and the block is idle.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: latency from accept to first out_valid, and product compare on each handshake.
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  pend = 1'b0;
    bit  prev_ov = 1'b0;
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        logic [2*W-1:0] eu;
        cyc++;
        if (!rst) begin
            pend    = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && pend) begin
                check("latency", 64'(cyc - acc_cyc), 64'(W + 1));
                pend = 1'b0;
            end
            if (in_valid && in_ready) begin
                acc_cyc = cyc;
                pend    = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got product 0x%0h with no expected entry", product);
                end else begin
                    e  = exp_q.pop_front();
                    eu = exp_uq.pop_front();
                    check("product", 64'(product), 64'(e));
                    check("u_out_valid", 64'(u_out_valid), 64'(1));
                    check("u_product", 64'(u_product), 64'(eu));
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        signed_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product",   64'(product),   64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_u_in_ready", 64'(u_in_ready), 64'(1));

        // Back-to-back directed ops with in_valid held high.
        for (int i = 0; i < int'(NV); i++) begin
            issue(VA[i], VB[i], VM[i], VE[i], VU[i], 1'b1);
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: result must hold while out_ready is low; new operands ignored.
        out_ready = 1'b0;
        issue(16'h0100, 16'h0003, 1'b0, 32'h00000300, 32'h00000300, 1'b1);
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        in_valid     = 1'b1;
        multiplicand = 16'h5555;
        multiplier   = 16'h0003;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_product",   64'(product),   64'(32'h00000300));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_busy",      64'(busy),      64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while CALC with count=5: operation discarded.
        issue(16'h1111, 16'h2222, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(1));
        check("midrst_busy",      64'(busy),      64'(0));
        issue(16'h0006, 16'h0007, 1'b1, 32'h0000002A, 32'h0000002A, 1'b1);
        in_valid = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
